seg7_count_decoder: RTL and testbench
=====================================

// Module: seg7_count_decoder
// PURPOSE
//  Receive side of the two-digit 7-segment counter bus. Samples the 14-bit active-low
//  segment word, waits for it to settle, decodes it back to binary/BCD and checks that
//  successive values step by +1. Lets logic or a bench read a display-driving counter.
// PARAMETERS
//  STABLE_CYCLES  2   consecutive cycles a new pattern must hold before acceptance (>=1)
//  MAX_VALUE      99  last count before wrap to 0; used only by the step check (<=99)
// PORTS
//  clk       in   1   system clock, all logic on rising edge
//  rst       in   1   synchronous reset, active-high
//  seg_in    in   14  [13:7] units digit, [6:0] tens digit; each gfedcba, active-low
//  value     out  7   accepted count, binary 0..99
//  bcd       out  8   accepted count, {tens,units} BCD
//  valid     out  1   1-cycle pulse: new legal value on value/bcd
//  illegal   out  1   1-cycle pulse: settled pattern undecodable
//  step_err  out  1   1-cycle pulse with valid: value != expected successor
//  locked    out  1   level: an accepted pattern is currently held
// BEHAVIOUR
//  Reset: value=0, bcd=0, valid=0, illegal=0, step_err=0, locked=0; state S_INIT;
//   history cleared (next accept skips step check). Reset wins over all other events.
//  Input: seg_q <= seg_in every edge. stab_cnt = consecutive edges seg_q unchanged;
//   reloads 1 on any change, saturates at STABLE_CYCLES.
//  Legal digit codes: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//   6=0000010 7=1111000 8=0000000 9=0010000. Tens also accepts 1111111 (blank)=0.
//   Units blank, or any other code in either field, is illegal.
//  FSM:
//   S_INIT   : stab_cnt reaches STABLE_CYCLES -> accept, no step check -> S_LOCKED.
//   S_LOCKED : locked=1; seg_q != accepted pattern -> S_SETTLE, stab_cnt=1.
//   S_SETTLE : locked=0; seg_q changes -> stay, stab_cnt=1; stab_cnt reaches
//              STABLE_CYCLES: pattern == accepted -> S_LOCKED silently (glitch);
//              else accept -> S_LOCKED.
//  Accept (registered, outputs update next edge): latency = STABLE_CYCLES+1 edges
//   from first edge sampling the new pattern to valid/illegal high.
//   Legal: value = 10*tens+units, bcd updated, valid=1 for one cycle.
//   Illegal: illegal=1 one cycle; value/bcd hold; pattern still recorded as accepted
//    (no repeat pulse while held); step history cleared.
//  Step check (legal accept with history): expected = (prev==MAX_VALUE)?0:prev+1;
//   mismatch -> step_err=1 in same cycle as valid. Tens "0" vs blank are equal values;
//   a re-accept of same value is a step error.
//  valid and illegal are never high together; step_err only with valid.
// TESTING
//  1 rst 1 cycle, seg_in=14'b1000000_1111111 held -> valid at 3rd edge after rst
//    release, value=0, bcd=8'h00, step_err=0, locked=1 thereafter.
//  2 patterns 0,1,2,3 (units 1000000,1111001,0100100,0110000, tens blank) 4 cycles
//    each -> 4 valid pulses, value 0,1,2,3, step_err never set.
//  3 from locked 1, apply 3 (0110000_1111111) -> valid, value=3, step_err=1.
//  4 hold 2, 1-cycle glitch 14'h0000 (all segs on), back to 2 -> no valid/illegal,
//    locked drops then returns to 1, value stays 2.
//  5 apply 14'h3FFF (both blank) held 5 cycles -> one illegal pulse, value unchanged,
//    next legal value gives valid with step_err=0.
//  6 99 (0010000_0010000) then 0 (1000000_1111111) -> valid value=0 step_err=0;
//    rst asserted during S_SETTLE -> all outputs 0, next accept step_err=0.

Source files
------------

// File: rtl/seg7_count_decoder.sv
// ---------------------------------------------------------------------------
// seg7_count_decoder
//
// Receive side of the two-digit 7-segment counter bus. The 14-bit active-low
// segment word is registered, and it must hold still for STABLE_CYCLES edges
// before it is accepted. An accepted word is decoded back to binary and BCD.
// Each legal value is checked to be the successor of the previous one, with
// the count wrapping after MAX_VALUE.
//
// Parameters
//   STABLE_CYCLES : number of consecutive edges a new pattern must hold (>=1)
//   MAX_VALUE     : last count before the wrap to 0 (<=99); used only by the
//                   step check
//
// Ports
//   clk      in   1   system clock, rising edge
//   rst      in   1   synchronous reset, active-high
//   seg_in   in  14   [13:7] units digit, [6:0] tens digit, gfedcba, active-low
//   value    out  7   accepted count, binary 0..99
//   bcd      out  8   accepted count, {tens, units} BCD
//   valid    out  1   one-cycle pulse: new legal value on value/bcd
//   illegal  out  1   one-cycle pulse: settled pattern could not be decoded
//   step_err out  1   one-cycle pulse with valid: value is not the successor
//   locked   out  1   level: an accepted pattern is currently being held
// ---------------------------------------------------------------------------
module seg7_count_decoder #(
  parameter int STABLE_CYCLES = 2,
  parameter int MAX_VALUE     = 99
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] seg_in,
  output logic [6:0]  value,
  output logic [7:0]  bcd,
  output logic        valid,
  output logic        illegal,
  output logic        step_err,
  output logic        locked
);

  localparam int              CNT_W   = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [6:0]       MAX_V   = 7'(MAX_VALUE);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_LOCKED = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  // Stability counter increment that stops at the acceptance threshold.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c >= CNT_MAX) begin
      return CNT_MAX;
    end
    return c + 1'b1;
  endfunction

  // Decodes one active-low gfedcba digit. Returns {legal, digit}.
  // An all-off field counts as 0 only where blanking is allowed (tens).
  function automatic logic [4:0] dec_digit(input logic [6:0] code,
                                           input logic       blank_ok);
    case (code)
      7'b1000000: return {1'b1, 4'd0};
      7'b1111001: return {1'b1, 4'd1};
      7'b0100100: return {1'b1, 4'd2};
      7'b0110000: return {1'b1, 4'd3};
      7'b0011001: return {1'b1, 4'd4};
      7'b0010010: return {1'b1, 4'd5};
      7'b0000010: return {1'b1, 4'd6};
      7'b1111000: return {1'b1, 4'd7};
      7'b0000000: return {1'b1, 4'd8};
      7'b0010000: return {1'b1, 4'd9};
      7'b1111111: return {blank_ok, 4'd0};
      default:    return 5'b0_0000;
    endcase
  endfunction

  // Successor of the previous count, wrapping after MAX_VALUE.
  function automatic logic [6:0] next_count(input logic [6:0] prev);
    if (prev == MAX_V) begin
      return 7'd0;
    end
    return prev + 7'd1;
  endfunction

  logic [13:0]      seg_q;
  logic [CNT_W-1:0] stab_cnt;
  logic [13:0]      acc_pat;
  state_t           state;
  logic             hist;

  logic             stab_done;
  logic             pat_new;
  logic             accept;
  logic [4:0]       units_dec;
  logic [4:0]       tens_dec;
  logic             pat_legal;
  logic [6:0]       dec_value;
  logic [7:0]       dec_bcd;

  // ---- input sample stage: register the bus, count how long it has held ----
  always_ff @(posedge clk) begin
    seg_q <= seg_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stab_cnt <= '0;
    end else if (seg_in != seg_q) begin
      stab_cnt <= CNT_W'(1);
    end else begin
      stab_cnt <= sat_inc(stab_cnt);
    end
  end

  // ---- decode / acceptance decision on the registered pattern ----
  always_comb begin
    units_dec = dec_digit(seg_q[13:7], 1'b0);
    tens_dec  = dec_digit(seg_q[6:0], 1'b1);
    pat_legal = units_dec[4] & tens_dec[4];
    dec_value = 7'(tens_dec[3:0]) * 7'd10 + 7'(units_dec[3:0]);
    dec_bcd   = {tens_dec[3:0], units_dec[3:0]};
    stab_done = (stab_cnt == CNT_MAX);
    pat_new   = (seg_q != acc_pat);
    // Before the first acceptance there is no reference pattern, so any
    // settled pattern is taken. After that only a settled pattern that differs
    // from the accepted one is taken. A settled return to the accepted pattern
    // is a glitch and produces no pulse.
    accept    = stab_done & ((state == S_INIT) | pat_new);
  end

  // The accepted pattern is kept even when it is illegal. This stops a held
  // illegal word from pulsing again.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_pat <= seg_q;
    end
  end

  // ---- output register stage: FSM, pulses, accepted value, step history ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT;
      value    <= '0;
      bcd      <= '0;
      valid    <= 1'b0;
      illegal  <= 1'b0;
      step_err <= 1'b0;
      locked   <= 1'b0;
      hist     <= 1'b0;
    end else begin
      valid    <= 1'b0;
      illegal  <= 1'b0;
      step_err <= 1'b0;

      if (accept) begin
        if (pat_legal) begin
          value    <= dec_value;
          bcd      <= dec_bcd;
          valid    <= 1'b1;
          // Blank and "0" tens decode to the same value, so they compare
          // equal here. Re-accepting the same value is not a successor, so
          // it is reported as a step error.
          step_err <= hist & (dec_value != next_count(value));
          hist     <= 1'b1;
        end else begin
          illegal  <= 1'b1;
          hist     <= 1'b0;
        end
      end

      case (state)
        S_INIT: begin
          if (stab_done) begin
            state  <= S_LOCKED;
            locked <= 1'b1;
          end
        end
        S_LOCKED: begin
          // With a one-cycle threshold a change is already settled when it is
          // first seen, so it is accepted in place without leaving S_LOCKED.
          if (pat_new && !stab_done) begin
            state  <= S_SETTLE;
            locked <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (stab_done) begin
            state  <= S_LOCKED;
            locked <= 1'b1;
          end
        end
        default: begin
          state  <= S_INIT;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_count_decoder.sv
module tb_seg7_count_decoder;

  localparam int S    = 2;
  localparam int MAXV = 99;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic        clk;
  logic        rst;
  logic [13:0] seg_in;
  logic [6:0]  value;
  logic [7:0]  bcd;
  logic        valid;
  logic        illegal;
  logic        step_err;
  logic        locked;

  int checks   = 0;
  int failures = 0;

  seg7_count_decoder #(
    .STABLE_CYCLES(S),
    .MAX_VALUE    (MAXV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .seg_in  (seg_in),
    .value   (value),
    .bcd     (bcd),
    .valid   (valid),
    .illegal (illegal),
    .step_err(step_err),
    .locked  (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] code_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return BLANK;
    endcase
  endfunction

  // Builds the bus word for a count. Values below 10 show a blank tens digit
  // unless tens_zero asks for an explicit "0".
  function automatic logic [13:0] pat_of(input int v, input bit tens_zero);
    logic [6:0] t;
    t = (v / 10 == 0 && !tens_zero) ? BLANK : code_of(v / 10);
    return {code_of(v % 10), t};
  endfunction

  // Digit lookup by search over the legal code table; -1 means undecodable.
  function automatic int dec7(input logic [6:0] c, input bit blank_ok);
    for (int d = 0; d < 10; d++) begin
      if (c == code_of(d)) return d;
    end
    if (blank_ok && c == BLANK) return 0;
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model. It tracks the run length of the sampled word and the
  // last accepted word. A word that has held for S edges and differs from
  // the accepted word (or when nothing is accepted yet) is accepted.
  // ------------------------------------------------------------------
  logic [13:0] m_q;
  logic [13:0] m_acc;
  int          m_run;
  bit          m_has;
  bit          m_hist;
  int          m_val;
  bit          e_valid, e_illegal, e_step, e_locked;
  bit          started = 1'b0;

  always @(posedge clk) begin
    logic [13:0] p;
    int r, u, t, v;
    p = m_q;
    r = m_run;
    if (rst) begin
      started   = 1'b1;
      m_has     = 1'b0;
      m_hist    = 1'b0;
      m_val     = 0;
      e_valid   = 1'b0;
      e_illegal = 1'b0;
      e_step    = 1'b0;
      e_locked  = 1'b0;
    end else if (started) begin
      e_valid   = 1'b0;
      e_illegal = 1'b0;
      e_step    = 1'b0;
      if (r >= S && (!m_has || p != m_acc)) begin
        u = dec7(p[13:7], 1'b0);
        t = dec7(p[6:0], 1'b1);
        m_has    = 1'b1;
        m_acc    = p;
        e_locked = 1'b1;
        if (u < 0 || t < 0) begin
          e_illegal = 1'b1;
          m_hist    = 1'b0;
        end else begin
          v = t * 10 + u;
          if (m_hist && v != ((m_val == MAXV) ? 0 : m_val + 1)) e_step = 1'b1;
          m_val   = v;
          e_valid = 1'b1;
          m_hist  = 1'b1;
        end
      end else if (r >= S) begin
        e_locked = m_has;
      end else if (m_has && p != m_acc) begin
        e_locked = 1'b0;
      end
    end
    if (rst) m_run = 0;
    else if (seg_in != m_q) m_run = 1;
    else m_run = (m_run + 1 > S) ? S : m_run + 1;
    m_q = seg_in;
  end

  // Compare process plus pulse counters used by the directed checks.
  int n_valid = 0, n_illegal = 0, n_step = 0, n_unlock = 0;

  always @(negedge clk) begin
    if (started) begin
      chk("value",    int'(value),    m_val);
      chk("bcd",      int'(bcd),      ((m_val / 10) << 4) | (m_val % 10));
      chk("valid",    int'(valid),    int'(e_valid));
      chk("illegal",  int'(illegal),  int'(e_illegal));
      chk("step_err", int'(step_err), int'(e_step));
      chk("locked",   int'(locked),   int'(e_locked));
      n_valid   += int'(valid);
      n_illegal += int'(illegal);
      n_step    += int'(step_err);
      n_unlock  += int'(!locked);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  int bv, bi, bs, bu;
  int cur;
  logic [13:0] prev_pat;

  initial begin
    // Test 1: power-on acceptance latency
    rst    = 1'b1;
    seg_in = 14'b1000000_1111111;
    cyc(1);
    rst = 1'b0;
    cyc(2);
    chk("t1_no_valid_early", int'(valid), 0);
    cyc(1);
    chk("t1_valid",    int'(valid), 1);
    chk("t1_value",    int'(value), 0);
    chk("t1_bcd",      int'(bcd), 8'h00);
    chk("t1_step_err", int'(step_err), 0);
    cyc(1);
    chk("t1_locked",   int'(locked), 1);

    // Test 2: counting 0..3 from reset
    seg_in = pat_of(0, 1'b0);
    bv = n_valid; bs = n_step;
    do_reset();
    cyc(3);
    for (int k = 1; k <= 3; k++) begin
      seg_in = pat_of(k, 1'b0);
      cyc(4);
    end
    cyc(3);
    chk("t2_valid_count", n_valid - bv, 4);
    chk("t2_step_count",  n_step - bs, 0);
    chk("t2_value",       int'(value), 3);

    // Test 3: skip from 1 to 3
    seg_in = pat_of(1, 1'b0);
    do_reset();
    cyc(5);
    bv = n_valid; bs = n_step;
    seg_in = 14'b0110000_1111111;
    cyc(5);
    chk("t3_valid_count", n_valid - bv, 1);
    chk("t3_step_count",  n_step - bs, 1);
    chk("t3_value",       int'(value), 3);

    // Test 4: one-cycle glitch while holding 2
    seg_in = pat_of(2, 1'b0);
    cyc(5);
    bv = n_valid; bi = n_illegal; bu = n_unlock;
    seg_in = 14'h0000;
    cyc(1);
    seg_in = pat_of(2, 1'b0);
    cyc(5);
    chk("t4_valid_count",   n_valid - bv, 0);
    chk("t4_illegal_count", n_illegal - bi, 0);
    chk("t4_locked_drop",   (n_unlock - bu > 0) ? 1 : 0, 1);
    chk("t4_locked",        int'(locked), 1);
    chk("t4_value",         int'(value), 2);

    // Test 5: both digits blank is illegal and clears history
    bv = n_valid; bi = n_illegal; bs = n_step;
    seg_in = 14'h3FFF;
    cyc(5);
    chk("t5_illegal_count", n_illegal - bi, 1);
    chk("t5_value_hold",    int'(value), 2);
    chk("t5_no_valid",      n_valid - bv, 0);
    seg_in = pat_of(5, 1'b0);
    cyc(5);
    chk("t5_valid_after",   n_valid - bv, 1);
    chk("t5_no_step_err",   n_step - bs, 0);

    // Test 6: wrap 99 -> 0, then reset while settling
    seg_in = 14'b0010000_0010000;
    cyc(5);
    chk("t6_value99", int'(value), 99);
    bv = n_valid; bs = n_step;
    seg_in = 14'b1000000_1111111;
    cyc(5);
    chk("t6_wrap_valid", n_valid - bv, 1);
    chk("t6_wrap_step",  n_step - bs, 0);
    chk("t6_wrap_value", int'(value), 0);
    seg_in = pat_of(5, 1'b1);
    cyc(2);
    chk("t6_settling", int'(locked), 0);
    rst = 1'b1;
    cyc(1);
    chk("t6_rst_value",  int'(value), 0);
    chk("t6_rst_bcd",    int'(bcd), 0);
    chk("t6_rst_valid",  int'(valid), 0);
    chk("t6_rst_locked", int'(locked), 0);
    rst = 1'b0;
    bv = n_valid; bs = n_step;
    seg_in = pat_of(7, 1'b0);
    cyc(5);
    chk("t6_after_valid", n_valid - bv, 1);
    chk("t6_after_step",  n_step - bs, 0);
    chk("t6_after_value", int'(value), 7);

    // Randomized traffic
    cur = 7;
    prev_pat = seg_in;
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 65) begin
        cur = (cur == MAXV) ? 0 : cur + 1;
        seg_in = pat_of(cur, 1'($urandom_range(0, 1)));
        prev_pat = seg_in;
        cyc($urandom_range(1, 5));
      end else if (r < 75) begin
        cur = $urandom_range(0, 99);
        seg_in = pat_of(cur, 1'($urandom_range(0, 1)));
        prev_pat = seg_in;
        cyc($urandom_range(1, 5));
      end else if (r < 85) begin
        seg_in = 14'($urandom);
        prev_pat = seg_in;
        cyc($urandom_range(1, 5));
      end else if (r < 95) begin
        seg_in = 14'($urandom);
        cyc(1);
        seg_in = prev_pat;
        cyc($urandom_range(1, 5));
      end else begin
        do_reset();
        cyc($urandom_range(1, 3));
      end
    end
    cyc(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
